uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of byte-stream requesters, range 2..8.
REQ-002 SHALL have parameter MAX_BYTES, default 64: maximum bytes per grant before forced release.
REQ-003 SHALL have parameter STALL_LIMIT, default 255: consecutive cycles without req_tvalid during a grant before forced release.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_tdata  input  NREQ*8  requester bytes, requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_tvalid  input  NREQ  per-requester byte valid.
REQ-008 SHALL have port req_tlast  input  NREQ  per-requester last byte of message.
REQ-009 SHALL have port req_tready  output  NREQ  per-requester byte accepted.
REQ-010 SHALL have port m_tdata  output  8  byte to UART transmit stream.
REQ-011 SHALL have port m_tvalid  output  1  byte valid to UART.
REQ-012 SHALL have port m_tready  input  1  UART transmit ready.
REQ-013 SHALL have port grant_id  output  clog2(NREQ)  index of granted requester, valid while busy.
REQ-014 SHALL have port busy  output  1  high while a grant is held.
REQ-015 SHALL have port forced_rel  output  1  one-cycle pulse on MAX_BYTES or STALL_LIMIT release.

Function
REQ-016 SHALL implement states IDLE and GRANT.
REQ-017 In IDLE with any req_tvalid high, SHALL select the first valid requester searching from last_grant+1 upward, wrapping modulo NREQ, register it into grant_id and enter GRANT next cycle; arbitration latency is exactly one cycle.
REQ-018 In IDLE, m_tvalid and all req_tready SHALL be 0.
REQ-019 In GRANT, m_tdata and m_tvalid SHALL combinationally equal req_tdata and req_tvalid of grant_id; req_tready[grant_id] SHALL equal m_tready; all other req_tready SHALL be 0.
REQ-020 A byte transfers when m_tvalid and m_tready are both high; byte counter increments per transfer, width clog2(MAX_BYTES+1).
REQ-021 A transfer with tlast high SHALL return to IDLE, set last_grant to grant_id, clear counters.
REQ-022 When the counter reaches MAX_BYTES without tlast, SHALL return to IDLE, update last_grant and pulse forced_rel.
REQ-023 Stall counter SHALL increment each GRANT cycle with granted req_tvalid low and clear on any cycle it is high. On reaching STALL_LIMIT, SHALL release as in REQ-022.
REQ-024 Simultaneous tlast transfer and limit hit SHALL be treated as normal tlast release; forced_rel stays 0.
REQ-025 A sole requester SHALL be re-granted after exactly one IDLE cycle; no requester with tvalid high is skipped more than NREQ-1 consecutive grants.
REQ-026 Requests asserted during GRANT SHALL not preempt the current grant.

Reset
REQ-027 On rst high, state SHALL be IDLE; grant_id 0; busy 0; forced_rel 0; m_tvalid 0; req_tready all 0; counters 0; last_grant NREQ-1, so requester 0 wins first.
REQ-028 Reset asserted mid-message SHALL abandon it immediately with no further handshake; after release, arbitration restarts per REQ-027.

Structure
REQ-029 Package uart_arb_pkg SHALL hold the state enum and byte-width constant (8).
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs (valid vector, last_grant) and outputs (found, index).

Verification
REQ-031 Reset with requesters 0 and 2 valid -> requester 0 granted first, then 2; m_tvalid 0 during reset and the IDLE cycle.
REQ-032 All 4 requesters send 3-byte messages continuously -> grant order 0,1,2,3,0, each with 3 bytes contiguous on m_tdata.
REQ-033 m_tready toggling 1 cycle high / 3 low during a 5-byte message -> no byte lost or duplicated, m_tdata stable while m_tvalid and not m_tready.
REQ-034 MAX_BYTES=4, requester 1 sends 6 bytes without tlast, requester 2 waiting -> release after byte 4, forced_rel pulses once, requester 2 granted next.
REQ-035 STALL_LIMIT=10, granted requester drops tvalid after 1 byte -> forced release on tenth stall cycle, busy low the following cycle.
REQ-036 rst pulse after byte 2 of a 5-byte message -> all outputs return to reset values asynchronously; after release, requester 0 with tvalid high is granted next.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  // Width of one stream byte.
  localparam int unsigned ByteW = 8;

  // Arbiter control states.
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of valid strictly above
// last_grant, wrapping modulo NREQ, so last_grant itself is considered last.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int unsigned IdW = $clog2(NREQ);

  logic [IdW-1:0] cand;

  // Scan NREQ positions starting just above last_grant; first hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IdW'((32'(last_grant) + off) % NREQ);
      if (!found && valid[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges NREQ byte streams onto one UART transmit
// stream. A grant is held for a whole message (until tlast) unless the byte
// budget or the stall budget runs out first, in which case forced_rel pulses.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned MAX_BYTES   = 64,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ*ByteW-1:0]   req_tdata,
  input  logic [NREQ-1:0]         req_tvalid,
  input  logic [NREQ-1:0]         req_tlast,
  output logic [NREQ-1:0]         req_tready,
  output logic [ByteW-1:0]        m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    forced_rel
);

  localparam int unsigned IdW    = $clog2(NREQ);
  localparam int unsigned CntW   = $clog2(MAX_BYTES + 1);
  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);

  arb_state_e        state_q, state_d;
  logic [IdW-1:0]    grant_id_q;
  logic [IdW-1:0]    last_grant_q;
  logic [CntW-1:0]   byte_cnt_q;
  logic [StallW-1:0] stall_cnt_q;
  logic              forced_rel_q;

  logic              pick_found;
  logic [IdW-1:0]    pick_idx;
  logic              in_grant;
  logic              gnt_valid;
  logic              gnt_last;
  logic [ByteW-1:0]  gnt_data;
  logic              xfer;
  logic              rel_last;
  logic              rel_forced;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .valid      (req_tvalid),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .index      (pick_idx)
  );

  assign in_grant  = (state_q == StGrant);
  assign gnt_valid = req_tvalid[grant_id_q];
  assign gnt_last  = req_tlast[grant_id_q];
  assign gnt_data  = req_tdata[grant_id_q*ByteW +: ByteW];
  assign xfer      = in_grant & gnt_valid & m_tready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and release decode; tlast outranks both budget limits.
  always_comb begin
    state_d    = state_q;
    rel_last   = 1'b0;
    rel_forced = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (xfer && gnt_last) begin
          rel_last = 1'b1;
        end else if (xfer && (byte_cnt_q == CntW'(MAX_BYTES - 1))) begin
          rel_forced = 1'b1;
        end else if (!gnt_valid && (stall_cnt_q == StallW'(STALL_LIMIT - 1))) begin
          rel_forced = 1'b1;
        end
        if (rel_last || rel_forced) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant bookkeeping: winner capture, round-robin pointer, byte/stall budgets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id_q   <= '0;
      last_grant_q <= IdW'(NREQ - 1);
      byte_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      forced_rel_q <= 1'b0;
    end else begin
      forced_rel_q <= rel_forced;
      if (!in_grant) begin
        byte_cnt_q  <= '0;
        stall_cnt_q <= '0;
        if (pick_found) begin
          grant_id_q <= pick_idx;
        end
      end else if (rel_last || rel_forced) begin
        last_grant_q <= grant_id_q;
        byte_cnt_q   <= '0;
        stall_cnt_q  <= '0;
      end else begin
        if (xfer) begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
        if (gnt_valid) begin
          stall_cnt_q <= '0;
        end else begin
          stall_cnt_q <= stall_cnt_q + 1'b1;
        end
      end
    end
  end

  // Outputs: granted lane is passed straight through; nothing moves in idle.
  always_comb begin
    busy       = in_grant;
    m_tvalid   = in_grant & gnt_valid;
    m_tdata    = in_grant ? gnt_data : '0;
    req_tready = '0;
    if (in_grant) begin
      req_tready[grant_id_q] = m_tready;
    end
  end

  assign grant_id   = grant_id_q;
  assign forced_rel = forced_rel_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte-stream sources, a behavioural
// arbitration model compared every cycle, and directed scenarios checked
// against fixed grant/release sequences.
module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int MAXB     = 4;
  localparam int STALL    = 10;
  localparam int EvForced = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ*8-1:0] req_tdata;
  logic [NREQ-1:0]   req_tvalid;
  logic [NREQ-1:0]   req_tlast;
  logic [NREQ-1:0]   req_tready;
  logic [7:0]        m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [1:0]        grant_id;
  logic              busy;
  logic              forced_rel;

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .MAX_BYTES   (MAXB),
    .STALL_LIMIT (STALL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_tdata  (req_tdata),
    .req_tvalid (req_tvalid),
    .req_tlast  (req_tlast),
    .req_tready (req_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .grant_id   (grant_id),
    .busy       (busy),
    .forced_rel (forced_rel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sources: per-requester byte memory {last, data} with head/tail pointers.
  logic [8:0] mem [NREQ][256];
  int head [NREQ];
  int tail [NREQ];
  bit src_v [NREQ];
  bit acc [NREQ];
  int vprob [NREQ];
  int sent_cnt [NREQ];
  int rdy_mode = 0;
  int cyc = 0;

  // Reference model state.
  int mdl_owner;
  int mdl_gid;
  int mdl_last;
  int mdl_bytes;
  int mdl_stall;
  bit mdl_forced;

  // Observed event log and busy-run measurement.
  int evlog[$];
  int exp_log[$];
  bit busy_prev;
  int busy_run;
  int last_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_msg(input int i, input int len, input bit has_last);
    if (head[i] == tail[i] && !src_v[i]) begin
      head[i] = 0;
      tail[i] = 0;
    end
    for (int k = 0; k < len; k++) begin
      mem[i][tail[i]] = {(has_last && (k == len - 1)), 8'($urandom_range(255))};
      tail[i]++;
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        head[i]++;
        src_v[i] = 1'b0;
        acc[i]   = 1'b0;
      end
      if (!src_v[i] && head[i] != tail[i] && int'($urandom_range(99)) < vprob[i]) begin
        src_v[i] = 1'b1;
      end
      req_tvalid[i] = src_v[i];
      if (src_v[i]) begin
        req_tdata[i*8 +: 8] = mem[i][head[i]][7:0];
        req_tlast[i]        = mem[i][head[i]][8];
      end else begin
        req_tdata[i*8 +: 8] = 8'($urandom_range(255));
        req_tlast[i]        = 1'($urandom_range(1));
      end
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(1));
      default: m_tready = ((cyc % 4) == 0);
    endcase
  endtask

  // Compare DUT against the model for this cycle, then advance the model
  // through the coming clock edge.
  task automatic eval_cycle();
    logic [NREQ-1:0] exp_rdy;
    bit own_v;
    bit x;
    bit fnext;
    bit found;
    int cand;
    own_v   = 1'b0;
    exp_rdy = '0;
    if (mdl_owner >= 0) begin
      own_v              = req_tvalid[mdl_owner];
      exp_rdy[mdl_owner] = m_tready;
    end
    check("busy", busy, mdl_owner >= 0);
    check("forced_rel", forced_rel, mdl_forced);
    check("m_tvalid", m_tvalid, own_v);
    check("req_tready", req_tready, exp_rdy);
    if (mdl_owner >= 0) check("grant_id", grant_id, mdl_gid);
    if (own_v) check("m_tdata", m_tdata, req_tdata[mdl_owner*8 +: 8]);

    if (forced_rel) evlog.push_back(EvForced);
    if (busy && !busy_prev) evlog.push_back(int'(grant_id));
    if (busy) busy_run++;
    else if (busy_prev) begin
      last_run = busy_run;
      busy_run = 0;
    end
    busy_prev = busy;

    for (int i = 0; i < NREQ; i++) begin
      acc[i] = src_v[i] && req_tready[i];
      if (acc[i]) sent_cnt[i]++;
    end

    fnext = 1'b0;
    if (mdl_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        cand = (mdl_last + k) % NREQ;
        if (!found && req_tvalid[cand]) begin
          found     = 1'b1;
          mdl_owner = cand;
          mdl_gid   = cand;
          mdl_bytes = 0;
          mdl_stall = 0;
        end
      end
    end else begin
      x = own_v && m_tready;
      if (x) mdl_bytes++;
      mdl_stall = own_v ? 0 : mdl_stall + 1;
      if ((x && req_tlast[mdl_owner]) || mdl_bytes == MAXB || mdl_stall == STALL) begin
        fnext     = !(x && req_tlast[mdl_owner]);
        mdl_last  = mdl_owner;
        mdl_owner = -1;
      end
    end
    mdl_forced = fnext;
  endtask

  task automatic cycle();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive_sources();
  endtask

  function automatic bit all_drained();
    bit d;
    d = (mdl_owner < 0) && !mdl_forced;
    for (int i = 0; i < NREQ; i++) begin
      if (head[i] != tail[i] || src_v[i]) d = 1'b0;
    end
    return d;
  endfunction

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_drained() && n < budget) begin
      cycle();
      n++;
    end
    check({tag, " drain in budget"}, n < budget, 1'b1);
  endtask

  task automatic compare_log(input string tag);
    check({tag, " log length"}, evlog.size(), exp_log.size());
    for (int k = 0; k < exp_log.size() && k < evlog.size(); k++) begin
      check(tag, evlog[k], exp_log[k]);
    end
  endtask

  // Raise reset (possibly mid-cycle), check the asynchronous effect, and
  // abandon all source traffic and model state.
  task automatic reset_begin();
    rst = 1'b1;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst forced_rel", forced_rel, 1'b0);
    check("rst m_tvalid", m_tvalid, 1'b0);
    check("rst req_tready", req_tready, '0);
    check("rst grant_id", grant_id, '0);
    for (int i = 0; i < NREQ; i++) begin
      head[i]     = 0;
      tail[i]     = 0;
      src_v[i]    = 1'b0;
      acc[i]      = 1'b0;
      sent_cnt[i] = 0;
      vprob[i]    = 100;
    end
    req_tvalid = '0;
    req_tlast  = '0;
    rdy_mode   = 0;
    mdl_owner  = -1;
    mdl_gid    = 0;
    mdl_last   = NREQ - 1;
    mdl_bytes  = 0;
    mdl_stall  = 0;
    mdl_forced = 1'b0;
    evlog.delete();
    busy_prev  = 1'b0;
    busy_run   = 0;
    last_run   = 0;
  endtask

  task automatic reset_end();
    @(posedge clk);
    #1;
    drive_sources();
    @(negedge clk);
    check("rst hold m_tvalid", m_tvalid, 1'b0);
    check("rst hold busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    req_tdata  = '0;
    req_tvalid = '0;
    req_tlast  = '0;
    m_tready   = 1'b1;
    #1;

    // Requesters 0 and 2 valid through reset: 0 wins first, then 2.
    reset_begin();
    push_msg(0, 2, 1'b1);
    push_msg(2, 2, 1'b1);
    reset_end();
    run_until_idle("s1", 200);
    exp_log = '{0, 2};
    compare_log("s1 order");

    // All four requesters stream 3-byte messages back to back.
    reset_begin();
    for (int i = 0; i < NREQ; i++) begin
      push_msg(i, 3, 1'b1);
      push_msg(i, 3, 1'b1);
    end
    reset_end();
    run_until_idle("s2", 400);
    exp_log = '{0, 1, 2, 3, 0, 1, 2, 3};
    compare_log("s2 order");

    // 5-byte message under a 1-high/3-low ready pattern; the byte budget
    // splits it, the sole requester is re-granted for the final byte.
    reset_begin();
    rdy_mode = 2;
    push_msg(0, 5, 1'b1);
    reset_end();
    run_until_idle("s3", 400);
    check("s3 bytes sent", sent_cnt[0], 5);
    exp_log = '{0, EvForced, 0};
    compare_log("s3 order");

    // Byte-budget release: requester 1 sends 6 bytes without tlast while
    // requester 2 waits; the leftover bytes end by stall release.
    reset_begin();
    push_msg(1, 6, 1'b0);
    reset_end();
    repeat (3) cycle();
    push_msg(2, 2, 1'b1);
    run_until_idle("s4", 400);
    exp_log = '{1, EvForced, 2, 1, EvForced};
    compare_log("s4 order");

    // Stall release: one byte then tvalid stays low.
    reset_begin();
    push_msg(0, 1, 1'b0);
    reset_end();
    run_until_idle("s5", 200);
    exp_log = '{0, EvForced};
    compare_log("s5 order");
    check("s5 busy cycles", last_run, 1 + STALL);

    // Reset after the second byte of a 5-byte message.
    reset_begin();
    push_msg(0, 5, 1'b1);
    reset_end();
    for (int n = 0; n < 50 && sent_cnt[0] < 2; n++) cycle();
    check("s6 bytes before rst", sent_cnt[0], 2);
    #2;
    check("s6 busy before rst", busy, 1'b1);
    reset_begin();
    push_msg(2, 2, 1'b1);
    push_msg(0, 3, 1'b1);
    reset_end();
    run_until_idle("s6", 200);
    exp_log = '{0, 2};
    compare_log("s6 order");

    // Randomised traffic, gaps and backpressure.
    reset_begin();
    reset_end();
    for (int r = 0; r < 40; r++) begin
      rdy_mode = $urandom_range(2);
      for (int i = 0; i < NREQ; i++) vprob[i] = 40 + $urandom_range(60);
      for (int m = 0; m < 1 + int'($urandom_range(3)); m++) begin
        push_msg($urandom_range(NREQ - 1), 1 + $urandom_range(5), $urandom_range(3) != 0);
      end
      run_until_idle("rand", 3000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
